// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the ctrl_sequencer control unit: FSM states, opcode values,
// opcode classes and the datapath strobe bundle.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_MEMWAIT,
      ST_EXEC,
      ST_HALT,
      ST_STEPWAIT
   } state_t;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_LDA = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_STA = 3'd4;
   localparam logic [2:0] OP_LDI = 3'd5;
   localparam logic [2:0] OP_JMP = 3'd6;
   localparam logic [2:0] OP_HLT = 3'd7;

   // How DECODE routes an instruction; undefined opcodes fall into K_RETIRE like NOP.
   typedef enum logic [2:0] {
      K_RETIRE,
      K_HALT,
      K_EXEC,
      K_MEMRD,
      K_STORE
   } kind_t;

   typedef struct packed {
      logic memRd;
      logic memWr;
      logic addrSel;
      logic pcInc;
      logic pcLoad;
      logic aLoad;
      logic immSel;
      logic aluEn;
      logic aluSub;
      logic halted;
   } strobes_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Memory/datapath bundle of the ctrl_sequencer; the sequencer takes the master
// view, memory and datapath the slave view.
interface ctrl_sequencer_if #(
   parameter int IW   = 8,
   parameter int OPW  = 3,
   parameter int CNTW = 16
);
   logic [IW-1:0]     instruction;
   logic              mem_ready;
   logic [OPW-1:0]    opcode;
   logic [IW-OPW-1:0] operand;
   logic              mem_rd;
   logic              mem_wr;
   logic              addr_sel;
   logic              pc_inc;
   logic              pc_load;
   logic              a_load;
   logic              imm_sel;
   logic              alu_en;
   logic              alu_sub;
   logic              illegal;
   logic              halted;
   logic [CNTW-1:0]   instr_count;

   modport master (
      input  instruction, mem_ready,
      output opcode, operand, mem_rd, mem_wr, addr_sel, pc_inc, pc_load,
             a_load, imm_sel, alu_en, alu_sub, illegal, halted, instr_count
   );

   modport slave (
      output instruction, mem_ready,
      input  opcode, operand, mem_rd, mem_wr, addr_sel, pc_inc, pc_load,
             a_load, imm_sel, alu_en, alu_sub, illegal, halted, instr_count
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational decoder: (state, opcode) -> Moore strobe vector, illegal flag
// and the opcode class the sequencer FSM uses for routing.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW = 3
)
(
   input  state_t         state_i,
   input  logic [OPW-1:0] opcode_i,
   output strobes_t       strobes_o,
   output kind_t          kind_o,
   output logic           illegal_o
);

   logic  hiBits;
   kind_t kind;

   // Any set bit above the 3-bit opcode space marks an undefined opcode.
   generate
      if (OPW > 3) begin : gWide
         assign hiBits = |opcode_i[OPW-1:3];
      end else begin : gNarrow
         assign hiBits = 1'b0;
      end
   endgenerate

   always_comb begin
      kind = K_RETIRE;
      if (!hiBits) begin
         case (opcode_i[2:0])
            OP_LDA, OP_ADD, OP_SUB: kind = K_MEMRD;
            OP_STA:                 kind = K_STORE;
            OP_LDI, OP_JMP:         kind = K_EXEC;
            OP_HLT:                 kind = K_HALT;
            default:                kind = K_RETIRE;
         endcase
      end
   end

   assign kind_o = kind;

   always_comb begin
      strobes_o = '0;
      illegal_o = 1'b0;
      case (state_i)
         ST_FETCH: strobes_o.memRd = 1'b1;
         ST_DECODE: begin
            strobes_o.pcInc = 1'b1;
            illegal_o       = hiBits;
         end
         ST_MEMWAIT: begin
            strobes_o.addrSel = 1'b1;
            if (kind == K_STORE) strobes_o.memWr = 1'b1;
            else                 strobes_o.memRd = 1'b1;
         end
         ST_EXEC: begin
            if (!hiBits) begin
               case (opcode_i[2:0])
                  OP_LDA: strobes_o.aLoad = 1'b1;
                  OP_ADD: begin
                     strobes_o.aLoad = 1'b1;
                     strobes_o.aluEn = 1'b1;
                  end
                  OP_SUB: begin
                     strobes_o.aLoad  = 1'b1;
                     strobes_o.aluEn  = 1'b1;
                     strobes_o.aluSub = 1'b1;
                  end
                  OP_LDI: begin
                     strobes_o.aLoad  = 1'b1;
                     strobes_o.immSel = 1'b1;
                  end
                  OP_JMP: strobes_o.pcLoad = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_HALT: strobes_o.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit: holds IR, steps the fetch/decode/execute FSM and
// counts retired instructions. Define CU_SINGLE_STEP_EN to add the step input.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int IW   = 8,
   parameter int OPW  = 3,
   parameter int CNTW = 16
)
(
   input logic clk,
   input logic rst_n,
`ifdef CU_SINGLE_STEP_EN
   input logic step,
`endif
   ctrl_sequencer_if.master bus
);

   // Every path back to FETCH funnels through this entry state.
`ifdef CU_SINGLE_STEP_EN
   localparam state_t FETCH_ENTRY = ST_STEPWAIT;
`else
   localparam state_t FETCH_ENTRY = ST_FETCH;
`endif

   state_t          state_q, state_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            retire;
   strobes_t        strobes;
   kind_t           kind;
   logic            illegal;

   ctrl_decode #(.OPW(OPW)) uDecode (
      .state_i   (state_q),
      .opcode_i  (ir_q[IW-1:IW-OPW]),
      .strobes_o (strobes),
      .kind_o    (kind),
      .illegal_o (illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE: state_d = FETCH_ENTRY;
         ST_FETCH: begin
            if (bus.mem_ready) begin
               ir_d    = bus.instruction;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (kind)
               K_HALT: begin
                  state_d = ST_HALT;
                  retire  = 1'b1;
               end
               K_EXEC:           state_d = ST_EXEC;
               K_MEMRD, K_STORE: state_d = ST_MEMWAIT;
               default: begin
                  state_d = FETCH_ENTRY;
                  retire  = 1'b1;
               end
            endcase
         end
         ST_MEMWAIT: begin
            if (bus.mem_ready) begin
               if (kind == K_STORE) begin
                  state_d = FETCH_ENTRY;
                  retire  = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            state_d = FETCH_ENTRY;
            retire  = 1'b1;
         end
         ST_HALT: state_d = ST_HALT;
`ifdef CU_SINGLE_STEP_EN
         ST_STEPWAIT: if (step) state_d = ST_FETCH;
`else
         ST_STEPWAIT: state_d = ST_FETCH;
`endif
         default: state_d = ST_IDLE;
      endcase
      count_d = count_q + CNTW'(retire);
   end

   assign bus.opcode      = ir_q[IW-1:IW-OPW];
   assign bus.operand     = ir_q[IW-OPW-1:0];
   assign bus.mem_rd      = strobes.memRd;
   assign bus.mem_wr      = strobes.memWr;
   assign bus.addr_sel    = strobes.addrSel;
   assign bus.pc_inc      = strobes.pcInc;
   assign bus.pc_load     = strobes.pcLoad;
   assign bus.a_load      = strobes.aLoad;
   assign bus.imm_sel     = strobes.immSel;
   assign bus.alu_en      = strobes.aluEn;
   assign bus.alu_sub     = strobes.aluSub;
   assign bus.illegal     = illegal;
   assign bus.halted      = strobes.halted;
   assign bus.instr_count = count_q;

endmodule
